// File: rtl/memory_request_pkg.sv
// memory_request_pkg: shared types for the memory request arbiter.
// Holds the FSM state encoding and the channel-id width helper.
package memory_request_pkg;

   typedef enum logic [1:0] {
      MRQ_IDLE  = 2'd0,
      MRQ_DATA  = 2'd1,
      MRQ_INSTR = 2'd2
   } mrq_state_t;

   localparam int MRQ_NCH_DEF = 2;

   // channel-id width, never narrower than one bit
   function automatic int mrq_cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/memory_request_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
// Grants the requester closest at or after ptr, wrapping.
module rr_arbiter
   import memory_request_pkg::*;
#(
   parameter  int NCH = MRQ_NCH_DEF,
   localparam int CW  = mrq_cw(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [CW-1:0]  ptr,
   output logic [CW-1:0]  gnt_id,
   output logic           any
);

   int w_dist;
   int w_best;

   // keep the requester with the smallest wrapped distance from ptr
   always_comb begin
      gnt_id = '0;
      any    = 1'b0;
      w_dist = 0;
      w_best = NCH;
      for (int c = 0; c < NCH; c++) begin
         w_dist = (c + NCH - int'(ptr)) % NCH;
         if (req[c] && (w_dist < w_best)) begin
            w_best = w_dist;
            gnt_id = CW'(c);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/memory_request_arbiter.sv
// memory_request_arbiter: NCH request channels onto one memory port.
// Data before fetch, round-robin per class, hit demux, sticky errors.
module memory_request_arbiter
   import memory_request_pkg::*;
#(
   parameter  int NCH   = MRQ_NCH_DEF,
   parameter  int TMO_W = 8,
   localparam int CW    = mrq_cw(NCH)
) (
   input  logic           CLK,
   input  logic           nRST,
   input  logic           ihit,
   input  logic           dhit,
   input  logic           halt,
   input  logic [NCH-1:0] iren,
   input  logic [NCH-1:0] dren,
   input  logic [NCH-1:0] dwen,
   output logic           imemREN,
   output logic           dmemREN,
   output logic           dmemWEN,
   output logic [CW-1:0]  grant_id,
   output logic [NCH-1:0] ihit_ch,
   output logic [NCH-1:0] dhit_ch,
   output logic           busy,
   output logic           timeout_err,
   output logic           proto_err
);

   localparam logic [TMO_W-1:0] TMO_MAX = '1;

   mrq_state_t       r_state;
   mrq_state_t       w_next;
   logic [CW-1:0]    r_gnt;
   logic [CW-1:0]    w_gnt;
   logic [CW-1:0]    r_dptr;
   logic [CW-1:0]    w_dptr;
   logic [CW-1:0]    r_iptr;
   logic [CW-1:0]    w_iptr;
   logic [CW-1:0]    w_gnt_inc;
   logic [CW-1:0]    w_dgnt;
   logic [CW-1:0]    w_ignt;
   logic             w_dany;
   logic             w_iany;
   logic             r_wr;
   logic             w_wr;
   logic             w_start;
   logic [NCH-1:0]   r_armed;
   logic [NCH-1:0]   w_pend;
   logic [TMO_W-1:0] r_cnt;
   logic             r_terr;
   logic             r_perr;

   assign w_pend = r_armed & (dren | dwen);

   rr_arbiter #(.NCH(NCH)) u_rr_data (
      .req    (w_pend),
      .ptr    (r_dptr),
      .gnt_id (w_dgnt),
      .any    (w_dany)
   );

   rr_arbiter #(.NCH(NCH)) u_rr_instr (
      .req    (iren),
      .ptr    (r_iptr),
      .gnt_id (w_ignt),
      .any    (w_iany)
   );

   assign w_gnt_inc = (int'(r_gnt) >= NCH - 1) ? '0 : r_gnt + CW'(1);

   // next state, grant capture and pointer advance
   always_comb begin
      w_next = r_state;
      w_gnt  = r_gnt;
      w_wr   = r_wr;
      w_dptr = r_dptr;
      w_iptr = r_iptr;
      unique case (r_state)
         MRQ_IDLE: begin
            if (!halt && w_dany) begin
               w_next = MRQ_DATA;
               w_gnt  = w_dgnt;
               w_wr   = dwen[w_dgnt];
            end else if (!halt && w_iany) begin
               w_next = MRQ_INSTR;
               w_gnt  = w_ignt;
               w_wr   = 1'b0;
            end
         end
         MRQ_DATA: begin
            if (dhit) begin
               w_next = MRQ_IDLE;
               w_dptr = w_gnt_inc;
            end
         end
         MRQ_INSTR: begin
            if (ihit) begin
               w_next = MRQ_IDLE;
               w_iptr = w_gnt_inc;
            end
         end
         default: w_next = MRQ_IDLE;
      endcase
   end

   assign w_start = (r_state == MRQ_IDLE) && (w_next != MRQ_IDLE);

   // state, owner, access kind and RR pointers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= MRQ_IDLE;
         r_gnt   <= '0;
         r_wr    <= 1'b0;
         r_dptr  <= '0;
         r_iptr  <= '0;
      end else begin
         r_state <= w_next;
         r_gnt   <= w_gnt;
         r_wr    <= w_wr;
         r_dptr  <= w_dptr;
         r_iptr  <= w_iptr;
      end
   end

   // route hits to the owner only in the matching state
   always_comb begin
      ihit_ch = '0;
      dhit_ch = '0;
      for (int c = 0; c < NCH; c++) begin
         dhit_ch[c] = dhit && (r_state == MRQ_DATA)
                   && (r_gnt == CW'(c));
         ihit_ch[c] = ihit && (r_state == MRQ_INSTR)
                   && (r_gnt == CW'(c));
      end
   end

   // a data hit disarms a channel until its next fetch lands
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_armed <= '1;
      end else begin
         r_armed <= (r_armed & ~dhit_ch) | ihit_ch;
      end
   end

   // stall counter and sticky error flags
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_cnt  <= '0;
         r_terr <= 1'b0;
         r_perr <= 1'b0;
      end else begin
         r_perr <= r_perr | (|(dren & dwen));
         if (w_start) begin
            r_cnt <= '0;
         end else if (r_state != MRQ_IDLE) begin
            if (r_cnt != TMO_MAX) begin
               r_cnt <= r_cnt + 1'b1;
            end
            if (r_cnt >= TMO_MAX - 1'b1) begin
               r_terr <= 1'b1;
            end
         end
      end
   end

   assign imemREN     = (r_state == MRQ_INSTR);
   assign dmemREN     = (r_state == MRQ_DATA) && !r_wr;
   assign dmemWEN     = (r_state == MRQ_DATA) && r_wr;
   assign busy        = (r_state != MRQ_IDLE);
   assign grant_id    = r_gnt;
   assign timeout_err = r_terr;
   assign proto_err   = r_perr;

endmodule

// File: tb/tb_memory_request_arbiter.sv
// tb_memory_request_arbiter: directed and random checks
// against a transaction-level model of the arbiter.
module tb_memory_request_arbiter;

   localparam int NCH   = 2;
   localparam int TMO_W = 3;
   localparam int CW    = 1;
   localparam int TMAX  = (1 << TMO_W) - 1;

   logic           CLK  = 1'b0;
   logic           nRST = 1'b0;
   logic           ihit = 1'b0;
   logic           dhit = 1'b0;
   logic           halt = 1'b0;
   logic [NCH-1:0] iren = '0;
   logic [NCH-1:0] dren = '0;
   logic [NCH-1:0] dwen = '0;
   logic           imemREN;
   logic           dmemREN;
   logic           dmemWEN;
   logic [CW-1:0]  grant_id;
   logic [NCH-1:0] ihit_ch;
   logic [NCH-1:0] dhit_ch;
   logic           busy;
   logic           timeout_err;
   logic           proto_err;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   // model: 0 idle, 1 data, 2 fetch
   int m_st;
   int m_g;
   int m_age;
   int m_dptr;
   int m_iptr;
   bit m_wr;
   bit m_terr;
   bit m_perr;
   bit m_armed [NCH];

   memory_request_arbiter #(.NCH(NCH), .TMO_W(TMO_W)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .ihit        (ihit),
      .dhit        (dhit),
      .halt        (halt),
      .iren        (iren),
      .dren        (dren),
      .dwen        (dwen),
      .imemREN     (imemREN),
      .dmemREN     (dmemREN),
      .dmemWEN     (dmemWEN),
      .grant_id    (grant_id),
      .ihit_ch     (ihit_ch),
      .dhit_ch     (dhit_ch),
      .busy        (busy),
      .timeout_err (timeout_err),
      .proto_err   (proto_err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string t, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
      end
   endtask

   function automatic int rr_pick(input bit req [NCH], input int ptr);
      for (int k = 0; k < NCH; k++) begin
         if (req[(ptr + k) % NCH]) return (ptr + k) % NCH;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_st = 0; m_g = 0; m_age = 0; m_dptr = 0; m_iptr = 0;
      m_wr = 0; m_terr = 0; m_perr = 0;
      for (int c = 0; c < NCH; c++) m_armed[c] = 1;
   endtask

   task automatic model_step();
      bit p [NCH];
      bit q [NCH];
      int pd;
      int pi;
      if ((dren & dwen) != '0) m_perr = 1;
      if (m_st == 0) begin
         for (int c = 0; c < NCH; c++) begin
            p[c] = m_armed[c] && (dren[c] || dwen[c]);
            q[c] = iren[c];
         end
         pd = rr_pick(p, m_dptr);
         pi = rr_pick(q, m_iptr);
         if (!halt && pd >= 0) begin
            m_st = 1; m_g = pd; m_wr = dwen[pd]; m_age = 0;
         end else if (!halt && pi >= 0) begin
            m_st = 2; m_g = pi; m_wr = 0; m_age = 0;
         end
      end else begin
         if (m_age < TMAX) m_age++;
         if (m_age == TMAX) m_terr = 1;
         if (m_st == 1 && dhit) begin
            m_armed[m_g] = 0;
            m_dptr = (m_g + 1) % NCH;
            m_st = 0;
         end else if (m_st == 2 && ihit) begin
            m_armed[m_g] = 1;
            m_iptr = (m_g + 1) % NCH;
            m_st = 0;
         end
      end
   endtask

   task automatic check_all(input string t);
      logic [7:0] edh;
      logic [7:0] eih;
      edh = (m_st == 1 && dhit) ? 8'(1 << m_g) : 8'h0;
      eih = (m_st == 2 && ihit) ? 8'(1 << m_g) : 8'h0;
      chk({t, ".imemREN"}, 8'(imemREN), 8'(m_st == 2));
      chk({t, ".dmemREN"}, 8'(dmemREN), 8'(m_st == 1 && !m_wr));
      chk({t, ".dmemWEN"}, 8'(dmemWEN), 8'(m_st == 1 && m_wr));
      chk({t, ".busy"}, 8'(busy), 8'(m_st != 0));
      chk({t, ".grant"}, 8'(grant_id), 8'(m_g));
      chk({t, ".dhit_ch"}, 8'(dhit_ch), edh);
      chk({t, ".ihit_ch"}, 8'(ihit_ch), eih);
      chk({t, ".tmo"}, 8'(timeout_err), 8'(m_terr));
      chk({t, ".proto"}, 8'(proto_err), 8'(m_perr));
   endtask

   // entered at posedge+1 with inputs already driven
   task automatic tick(input string t);
      #1;
      check_all(t);
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic clr_in();
      ihit = 0; dhit = 0; halt = 0;
      iren = '0; dren = '0; dwen = '0;
   endtask

   task automatic do_reset();
      clr_in();
      nRST = 1'b0;
      #1;
      model_reset();
      check_all("rst");
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   initial begin
      model_reset();
      @(posedge CLK);
      #1;
      check_all("por");
      nRST = 1'b1;

      // reset in the middle of a data access
      dren = 2'b01;
      tick("t1a");
      chk("t1_ren_on", 8'(dmemREN), 8'd1);
      tick("t1b");
      nRST = 1'b0;
      #1;
      chk("t1_ren_async", 8'(dmemREN), 8'd0);
      chk("t1_busy_async", 8'(busy), 8'd0);
      do_reset();

      // two data grants then wait for a re-arm
      dren = 2'b11;
      tick("t2c1");
      chk("t2_g0", 8'(grant_id), 8'd0);
      tick("t2c2");
      dhit = 1; tick("t2c3");
      dhit = 0; tick("t2c4");
      chk("t2_g1", 8'(grant_id), 8'd1);
      tick("t2c5");
      dhit = 1; tick("t2c6");
      dhit = 0; tick("t2c7");
      chk("t2_nogrant", 8'(busy), 8'd0);
      tick("t2c8");
      chk("t2_nogrant2", 8'(busy), 8'd0);
      iren = 2'b01; tick("t2c9");
      chk("t2_fetch", 8'(imemREN), 8'd1);
      ihit = 1; tick("t2c10");
      ihit = 0; iren = 2'b00; tick("t2c11");
      chk("t2_rearm_g", 8'(grant_id), 8'd0);
      chk("t2_rearm_ren", 8'(dmemREN), 8'd1);
      dhit = 1; tick("t2c12");
      do_reset();

      // data first, then the fetch after one dead cycle
      dren = 2'b01; iren = 2'b10;
      tick("t3c1");
      chk("t3_data_g", 8'(grant_id), 8'd0);
      chk("t3_data_ren", 8'(dmemREN), 8'd1);
      dhit = 1; tick("t3c2");
      dhit = 0;
      chk("t3_dead", 8'(busy), 8'd0);
      tick("t3c3");
      chk("t3_instr_g", 8'(grant_id), 8'd1);
      chk("t3_instr_ren", 8'(imemREN), 8'd1);
      ihit = 1; tick("t3c4");
      do_reset();

      // write on channel 1
      dwen = 2'b10;
      tick("t4c1");
      for (int i = 0; i < 2; i++) begin
         chk("t4_wen", 8'(dmemWEN), 8'd1);
         chk("t4_g", 8'(grant_id), 8'd1);
         chk("t4_nohit", 8'(dhit_ch), 8'd0);
         tick("t4w");
      end
      dhit = 1;
      #1;
      chk("t4_hitch", 8'(dhit_ch), 8'b10);
      tick("t4h");
      dhit = 0;
      #1;
      chk("t4_hitch_off", 8'(dhit_ch), 8'd0);
      tick("t4e");
      do_reset();

      // stalled access trips the timeout, late hit completes
      dren = 2'b01;
      tick("t5c0");
      for (int i = 0; i < 10; i++) begin
         chk("t5_tmo", 8'(timeout_err), 8'(i >= 7));
         tick("t5w");
      end
      dhit = 1; tick("t5h");
      dhit = 0;
      chk("t5_done", 8'(busy), 8'd0);
      chk("t5_sticky", 8'(timeout_err), 8'd1);
      tick("t5e");
      do_reset();

      // halt lets the fetch finish, then blocks grants
      iren = 2'b01;
      tick("t6c1");
      halt = 1; tick("t6c2");
      ihit = 1;
      chk("t6_fetch", 8'(imemREN), 8'd1);
      tick("t6c3");
      ihit = 0;
      for (int i = 0; i < 3; i++) begin
         chk("t6_halted", 8'(busy), 8'd0);
         tick("t6h");
      end
      halt = 0; iren = 2'b00;
      dren = 2'b01; dwen = 2'b01;
      tick("t6c4");
      chk("t6_wen", 8'(dmemWEN), 8'd1);
      chk("t6_ren", 8'(dmemREN), 8'd0);
      chk("t6_proto", 8'(proto_err), 8'd1);
      dhit = 1; tick("t6c5");
      do_reset();

      // random traffic against the model
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 79) == 0) do_reset();
         iren = 2'($urandom);
         dren = 2'($urandom);
         dwen = 2'($urandom);
         if ($urandom_range(0, 40) != 0) dwen = dwen & ~dren;
         halt = ($urandom_range(0, 7) == 0);
         ihit = ($urandom_range(0, 2) == 0);
         dhit = ($urandom_range(0, 2) == 0);
         tick("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
